// File: rtl/fpnew_pkg.sv
// Floating-point format descriptors: the subset of the FPnew package that the exponential
// unit needs to size its datapath.
package fpnew_pkg;

    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

    function automatic int unsigned exp_bits(input fp_format_e fmt);
        case (fmt)
            FP32:    return 8;
            FP64:    return 11;
            FP16:    return 5;
            FP8:     return 5;
            FP16ALT: return 8;
            default: return 8;
        endcase
    endfunction

    function automatic int unsigned man_bits(input fp_format_e fmt);
        case (fmt)
            FP32:    return 23;
            FP64:    return 52;
            FP16:    return 10;
            FP8:     return 2;
            FP16ALT: return 7;
            default: return 7;
        endcase
    endfunction

    function automatic int unsigned fp_width(input fp_format_e fmt);
        return 1 + exp_bits(fmt) + man_bits(fmt);
    endfunction

endpackage

// File: rtl/expu_schraudolph.sv
// Schraudolph exp(x) approximation: exponent field = bias + x*log2(e) in fixed point, written
// straight into the result bit pattern. Two-stage elastic pipeline; mantissa left uncorrected.
module expu_schraudolph #(
    parameter fpnew_pkg::fp_format_e FPFORMAT       = fpnew_pkg::FP16ALT,
    parameter int unsigned           LOG2E_FRACTION = 10,
    localparam int unsigned          WIDTH          = fpnew_pkg::fp_width(FPFORMAT)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] op_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] res_o
);

    localparam int unsigned EXP   = fpnew_pkg::exp_bits(FPFORMAT);
    localparam int unsigned MANT  = fpnew_pkg::man_bits(FPFORMAT);
    localparam int unsigned BIAS  = (2 ** (EXP - 1)) - 1;
    localparam int unsigned LOG2E =
        int'($rtoi(1.4426950408889634 * (2.0 ** LOG2E_FRACTION) + 0.5));

    localparam int unsigned PW = MANT + 1 + LOG2E_FRACTION + 2;  // product width
    localparam int unsigned SW = PW + EXP;                       // room for left shift < EXP
    localparam int unsigned RW = SW + 2;                         // signed biased result
    localparam int unsigned EW = EXP + 2;                        // signed unbiased exponent

    localparam logic signed [RW-1:0] R_MIN   = RW'(1) << MANT;
    localparam logic signed [RW-1:0] R_MAX   = RW'((2 ** EXP) - 1) << MANT;
    localparam logic signed [RW-1:0] R_BIAS  = RW'(BIAS) << MANT;
    localparam logic [WIDTH-1:0]     RES_ONE = WIDTH'(BIAS) << MANT;
    localparam logic [WIDTH-1:0]     RES_INF = {1'b0, {EXP{1'b1}}, {MANT{1'b0}}};
    localparam logic [WIDTH-1:0]     RES_NAN = {1'b0, {EXP{1'b1}}, 1'b1, {(MANT - 1){1'b0}}};

    // Handshake
    logic s1_valid_q, s2_valid_q;
    logic s2_ready, s1_adv, in_fire;

    assign s2_ready = ~s2_valid_q | ready_i;
    assign s1_adv   = s1_valid_q & s2_ready;
    assign ready_o  = ~s1_valid_q | s1_adv;
    assign in_fire  = valid_i & ready_o;
    assign valid_o  = s2_valid_q;

    // Stage 1: unpack, classify, multiply by log2(e)
    logic [EXP-1:0]  exp_fld;
    logic [MANT-1:0] man_fld;
    logic [PW-1:0]   prod_d;
    logic [EW-1:0]   uexp_d;
    logic            zero_d, inf_d, nan_d, shovf_d;

    always_comb begin
        exp_fld = op_i[WIDTH-2 -: EXP];
        man_fld = op_i[MANT-1:0];
        prod_d  = PW'({1'b1, man_fld}) * PW'(LOG2E);
        uexp_d  = EW'({2'b00, exp_fld}) - EW'(BIAS);
        zero_d  = (exp_fld == '0);
        inf_d   = (exp_fld == '1) & (man_fld == '0);
        nan_d   = (exp_fld == '1) & (man_fld != '0);
        shovf_d = ~uexp_d[EW-1] & (uexp_d >= EW'(EXP));
    end

    logic [PW-1:0] prod_q;
    logic [EW-1:0] exp_q;
    logic          sign_q, zero_q, inf_q, nan_q, shovf_q;

    // Stage 2: align to Q.MANT, add to the bias, saturate
    logic [SW-1:0]          p_ext, z;
    logic [EW-1:0]          neg_exp;
    logic [31:0]            rsh;
    logic signed [RW-1:0]   zs, r;
    logic [WIDTH-1:0]       res_d;

    always_comb begin
        p_ext   = SW'(prod_q);
        neg_exp = -exp_q;
        rsh     = LOG2E_FRACTION + 32'(neg_exp);
        if (!exp_q[EW-1]) begin
            z = (p_ext << exp_q) >> LOG2E_FRACTION;
        end else begin
            // Shift amounts past the width flush to zero
            z = p_ext >> rsh;
        end
        zs = $signed({2'b00, z});
        r  = sign_q ? (R_BIAS - zs) : (R_BIAS + zs);

        res_d = {1'b0, r[WIDTH-2:0]};
        if (nan_q) begin
            res_d = RES_NAN;
        end else if (inf_q) begin
            res_d = sign_q ? '0 : RES_INF;
        end else if (zero_q) begin
            res_d = RES_ONE;
        end else if (shovf_q) begin
            res_d = sign_q ? '0 : RES_INF;
        end else if (r < R_MIN) begin
            res_d = '0;
        end else if (r >= R_MAX) begin
            res_d = RES_INF;
        end
    end

    logic [WIDTH-1:0] res_q;
    assign res_o = res_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            prod_q     <= '0;
            exp_q      <= '0;
            sign_q     <= 1'b0;
            zero_q     <= 1'b0;
            inf_q      <= 1'b0;
            nan_q      <= 1'b0;
            shovf_q    <= 1'b0;
            res_q      <= '0;
        end else begin
            if (clear_i) begin
                s1_valid_q <= 1'b0;
                s2_valid_q <= 1'b0;
            end else begin
                s1_valid_q <= in_fire | (s1_valid_q & ~s2_ready);
                s2_valid_q <= s1_adv | (s2_valid_q & ~ready_i);
            end
            if (in_fire) begin
                prod_q  <= prod_d;
                exp_q   <= uexp_d;
                sign_q  <= op_i[WIDTH-1];
                zero_q  <= zero_d;
                inf_q   <= inf_d;
                nan_q   <= nan_d;
                shovf_q <= shovf_d;
            end
            if (s1_adv) begin
                res_q <= res_d;
            end
        end
    end

endmodule

// File: doc/expu_schraudolph.md
EXPU_SCHRAUDOLPH -- requirements
Module: expu_schraudolph

Interface
REQ-001 SHALL have parameter FPFORMAT, default fpnew_pkg::FP16ALT, operand format; WIDTH = fp_width, EXP = exp_bits, MANT = man_bits, BIAS = 2^(EXP-1)-1.
REQ-002 SHALL have parameter LOG2E_FRACTION, default 10, fraction bits of constant LOG2E = round(1.4426950408889634 * 2^LOG2E_FRACTION).
REQ-003 SHALL have port clk_i  input  1  clock; the block uses one clock only.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clear_i  input  1  synchronous pipeline flush.
REQ-006 SHALL have port valid_i  input  1  input operand valid.
REQ-007 SHALL have port ready_o  output  1  block accepts operand.
REQ-008 SHALL have port op_i  input  WIDTH  FP operand x.
REQ-009 SHALL have port valid_o  output  1  result valid.
REQ-010 SHALL have port ready_i  input  1  downstream (mantissa correction stage) accepts result.
REQ-011 SHALL have port res_o  output  WIDTH  uncorrected exp(x) bit pattern.

Function
REQ-012 SHALL form a 2-stage elastic pipeline: S1 unpacks and multiplies, S2 aligns, biases and saturates; latency exactly 2 cycles when ready_i held high.
REQ-013 SHALL load each stage when it is empty or its successor advances; ready_o = !S1.valid | S1 advances; full throughput 1 op/cycle.
REQ-014 SHALL transfer in on valid_i & ready_o and out on valid_o & ready_i; res_o and valid_o are held stable while valid_o & !ready_i.
REQ-015 SHALL S1: magnitude product P = {1,mant} * LOG2E, width MANT+1 + LOG2E_FRACTION+2, unsigned; register P, sign, unbiased exponent e-BIAS, and special-class flags.
REQ-016 SHALL S2: Z = floor(P * 2^(e-BIAS) / 2^LOG2E_FRACTION), i.e. |x|*log2e in Q.MANT fixed point, truncated toward zero; right shifts beyond width give Z = 0.
REQ-017 SHALL compute R = BIAS*2^MANT + Z for sign 0, BIAS*2^MANT - Z for sign 1, in signed arithmetic of at least EXP+MANT+2 bits.
REQ-018 SHALL output res_o = R[WIDTH-2:0] with sign bit 0 when 2^MANT <= R < (2^EXP-1)*2^MANT.
REQ-019 SHALL output +0 when R < 2^MANT (underflow, no subnormals) and +inf when R >= (2^EXP-1)*2^MANT (overflow).
REQ-020 SHALL short-circuit e-BIAS >= EXP (shift overflow) to +inf for sign 0, +0 for sign 1, without evaluating REQ-017.
REQ-021 SHALL treat zero and subnormal inputs (exponent field 0) as 0 -> res_o = BIAS<<MANT (1.0).
REQ-022 SHALL map +inf -> +inf, -inf -> +0, any NaN -> canonical quiet NaN (0, all-ones exp, MSB mantissa 1, rest 0).
REQ-023 SHALL on clear_i drop all in-flight operands (valid bits 0) in the following cycle; clear_i has priority over a simultaneous input handshake, which is discarded.
REQ-024 SHALL keep data registers enable-gated only; their contents are don't-care while their valid bit is 0.

Reset
REQ-025 SHALL asynchronously on rst_ni low clear both stage valid bits and zero all data registers: valid_o = 0, res_o = 0, ready_o = 1.
REQ-026 SHALL discard operands in flight when reset asserts mid-operation; first valid_o after release follows the first post-reset handshake by 2 cycles.

Verification (FP16ALT, LOG2E = 1477)
REQ-027 SHALL cover op_i 0x0000, 0x0001, 0x8000 -> res_o 0x3F80 each, valid_o 2 cycles after accept.
REQ-028 SHALL cover op_i 0x3F80 (1.0) -> 0x4038; op_i 0xBF80 (-1.0) -> 0x3EC8.
REQ-029 SHALL cover op_i 0x42C8 (100) -> 0x7F80; op_i 0xC2C8 (-100) -> 0x0000; op_i 0x4400 (512) -> 0x7F80.
REQ-030 SHALL cover op_i 0x7F80 -> 0x7F80, 0xFF80 -> 0x0000, 0x7FC1 -> 0x7FC0, 0xFF81 -> 0x7FC0.
REQ-031 SHALL cover back-to-back stream of 8 ops with ready_i low cycles 3-5: all 8 results in order, none lost or duplicated, res_o stable while stalled, ready_o low only when both stages full and stalled.
REQ-032 SHALL cover clear_i and, separately, rst_ni pulse with 2 ops in flight -> valid_o 0 next cycle / immediately, no stale result emitted afterwards.
